// File: rtl/axi4_lite_reg_slave.sv
// ---------------------------------------------------------------------------
// axi4_lite_reg_slave
//
// AXI4-Lite slave exposing REG_COUNT 32-bit read/write registers starting at
// BASE_ADDR. AW and W are captured into independent one-deep latches, in any
// order. The write commits in the same clock edge that makes both latches
// full, so BVALID rises the cycle after the second handshake. Reads return
// the register value sampled at the AR handshake; a same-edge write is not
// visible to that read.
//
// Ports
//   clk, resetn            clock, synchronous active-low reset
//   S_AXI_AW* / S_AXI_W*   write address / write data channels
//   S_AXI_B*               write response channel
//   S_AXI_AR* / S_AXI_R*   read address / read data channels
//   REG_OUT                all register contents, register n at [32n+31:32n]
//   WR_STROBE              one-cycle pulse on bit n when register n is written
// ---------------------------------------------------------------------------
module axi4_lite_reg_slave #(
   parameter int          AXI_DATA_WIDTH = 32,
   parameter int          AXI_ADDR_WIDTH = 32,
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter int          REG_COUNT      = 16
) (
   input  logic                          clk,
   input  logic                          resetn,
   input  logic [AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic                          S_AXI_AWVALID,
   input  logic [2:0]                    S_AXI_AWPROT,
   output logic                          S_AXI_AWREADY,
   input  logic [AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                          S_AXI_WVALID,
   output logic                          S_AXI_WREADY,
   output logic [1:0]                    S_AXI_BRESP,
   output logic                          S_AXI_BVALID,
   input  logic                          S_AXI_BREADY,
   input  logic [AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic                          S_AXI_ARVALID,
   input  logic [2:0]                    S_AXI_ARPROT,
   output logic                          S_AXI_ARREADY,
   output logic [AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                    S_AXI_RRESP,
   output logic                          S_AXI_RVALID,
   input  logic                          S_AXI_RREADY,
   output logic [REG_COUNT*32-1:0]       REG_OUT,
   output logic [REG_COUNT-1:0]          WR_STROBE
);

   localparam int DW   = AXI_DATA_WIDTH;
   localparam int SW   = AXI_DATA_WIDTH / 8;
   localparam int AW   = AXI_ADDR_WIDTH;
   localparam int AWP1 = AXI_ADDR_WIDTH + 1;
   localparam logic [AW-1:0] L_BASE = AW'(BASE_ADDR);
   localparam logic [AW:0]   L_SPAN = AWP1'(4 * REG_COUNT);
   localparam logic [1:0]    L_OKAY   = 2'b00;
   localparam logic [1:0]    L_SLVERR = 2'b10;

   // Subtraction is done one bit wider so an address below BASE_ADDR borrows
   // into the top bit and can never compare as a small in-range offset.
   function automatic logic f_in_range(input logic [AW-1:0] i_addr);
      logic [AW:0] w_diff;
      w_diff = {1'b0, i_addr} - {1'b0, L_BASE};
      return (w_diff < L_SPAN);
   endfunction

   function automatic logic [3:0] f_index(input logic [AW-1:0] i_addr);
      return 4'((i_addr - L_BASE) >> 2);
   endfunction

   function automatic logic [DW-1:0] f_merge(input logic [DW-1:0] i_old,
                                             input logic [DW-1:0] i_new,
                                             input logic [SW-1:0] i_strb);
      logic [DW-1:0] w_res;
      for (int b = 0; b < SW; b++) begin
         w_res[8*b +: 8] = i_strb[b] ? i_new[8*b +: 8] : i_old[8*b +: 8];
      end
      return w_res;
   endfunction

   // Register storage and outputs
   logic [DW-1:0]        r_regs [REG_COUNT];
   logic [REG_COUNT-1:0] r_wr_strobe;

   // Write path state
   logic          r_aw_full;
   logic [AW-1:0] r_aw_addr;
   logic          r_w_full;
   logic [DW-1:0] r_w_data;
   logic [SW-1:0] r_w_strb;
   logic          r_bvalid;
   logic [1:0]    r_bresp;
   logic          r_awready;
   logic          r_wready;

   // Read path state
   logic          r_rvalid;
   logic [DW-1:0] r_rdata;
   logic [1:0]    r_rresp;
   logic          r_arready;

   // Combinational helpers
   logic          w_aw_hs;
   logic          w_w_hs;
   logic          w_aw_avail;
   logic          w_w_avail;
   logic          w_commit;
   logic [AW-1:0] w_cmt_addr;
   logic [DW-1:0] w_cmt_data;
   logic [SW-1:0] w_cmt_strb;
   logic          w_cmt_hit;
   logic [3:0]    w_cmt_idx;
   logic          w_aw_full_nxt;
   logic          w_w_full_nxt;
   logic          w_bvalid_nxt;
   logic          w_ar_hs;
   logic          w_ar_hit;
   logic [3:0]    w_ar_idx;
   logic          w_rvalid_nxt;
   logic [DW-1:0] w_rd_data;
   logic          w_unused_prot;

   assign w_unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

   // A channel's payload is available either from its latch or from a
   // handshake happening this cycle; the commit uses whichever applies.
   assign w_aw_hs    = S_AXI_AWVALID & r_awready;
   assign w_w_hs     = S_AXI_WVALID & r_wready;
   assign w_aw_avail = r_aw_full | w_aw_hs;
   assign w_w_avail  = r_w_full | w_w_hs;
   assign w_commit   = w_aw_avail & w_w_avail;
   assign w_cmt_addr = r_aw_full ? r_aw_addr : S_AXI_AWADDR;
   assign w_cmt_data = r_w_full ? r_w_data : S_AXI_WDATA;
   assign w_cmt_strb = r_w_full ? r_w_strb : S_AXI_WSTRB;
   assign w_cmt_hit  = f_in_range(w_cmt_addr);
   assign w_cmt_idx  = f_index(w_cmt_addr);

   // Latches never fill while BVALID is high, so a commit and a B handshake
   // cannot coincide.
   assign w_aw_full_nxt = w_commit ? 1'b0 : w_aw_avail;
   assign w_w_full_nxt  = w_commit ? 1'b0 : w_w_avail;
   assign w_bvalid_nxt  = w_commit ? 1'b1 : (r_bvalid & ~S_AXI_BREADY);

   assign w_ar_hs      = S_AXI_ARVALID & r_arready;
   assign w_ar_hit     = f_in_range(S_AXI_ARADDR);
   assign w_ar_idx     = f_index(S_AXI_ARADDR);
   assign w_rvalid_nxt = w_ar_hs ? 1'b1 : (r_rvalid & ~S_AXI_RREADY);

   // Read data multiplexer; out-of-range addresses read as zero.
   always_comb begin
      w_rd_data = '0;
      for (int i = 0; i < REG_COUNT; i++) begin
         w_rd_data = (w_ar_hit && (w_ar_idx == 4'(i))) ? r_regs[i] : w_rd_data;
      end
   end

   // Write address/data latches, write response and write-side ready flags.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_aw_full <= 1'b0;
         r_aw_addr <= '0;
         r_w_full  <= 1'b0;
         r_w_data  <= '0;
         r_w_strb  <= '0;
         r_bvalid  <= 1'b0;
         r_bresp   <= L_OKAY;
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
      end else begin
         r_aw_full <= w_aw_full_nxt;
         r_w_full  <= w_w_full_nxt;
         if (w_aw_hs) begin
            r_aw_addr <= S_AXI_AWADDR;
         end
         if (w_w_hs) begin
            r_w_data <= S_AXI_WDATA;
            r_w_strb <= S_AXI_WSTRB;
         end
         r_bvalid <= w_bvalid_nxt;
         if (w_commit) begin
            r_bresp <= w_cmt_hit ? L_OKAY : L_SLVERR;
         end
         r_awready <= ~w_aw_full_nxt & ~w_bvalid_nxt;
         r_wready  <= ~w_w_full_nxt & ~w_bvalid_nxt;
      end
   end

   // Register file update with byte-lane merge and per-register write strobe.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            r_regs[i] <= '0;
         end
         r_wr_strobe <= '0;
      end else begin
         for (int i = 0; i < REG_COUNT; i++) begin
            if (w_commit && w_cmt_hit && (w_cmt_idx == 4'(i))) begin
               r_regs[i]      <= f_merge(r_regs[i], w_cmt_data, w_cmt_strb);
               r_wr_strobe[i] <= 1'b1;
            end else begin
               r_wr_strobe[i] <= 1'b0;
            end
         end
      end
   end

   // Read response; data is captured from the pre-write register contents.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= L_OKAY;
         r_arready <= 1'b0;
      end else begin
         r_rvalid  <= w_rvalid_nxt;
         r_arready <= ~w_rvalid_nxt;
         if (w_ar_hs) begin
            r_rdata <= w_rd_data;
            r_rresp <= w_ar_hit ? L_OKAY : L_SLVERR;
         end
      end
   end

   genvar g;
   for (g = 0; g < REG_COUNT; g++) begin : g_reg_out
      assign REG_OUT[32*g +: 32] = r_regs[g];
   end

   assign WR_STROBE     = r_wr_strobe;
   assign S_AXI_AWREADY = r_awready;
   assign S_AXI_WREADY  = r_wready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_ARREADY = r_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = r_rresp;

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_reg_slave
//
// Directed scenarios followed by randomized traffic. A transaction-level
// model (address arithmetic, pending AW/W queues, register array) predicts
// every output; a negedge compare process checks the DUT against it each
// cycle, and literal expectations pin the directed scenarios.
// ---------------------------------------------------------------------------
module tb_axi4_lite_reg_slave;

   localparam logic [31:0] BASE = 32'h0000_4000;
   localparam int          RC   = 12;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  s;
   } w_t;

   logic              clk;
   logic              resetn;
   logic [31:0]       S_AXI_AWADDR;
   logic              S_AXI_AWVALID;
   logic [2:0]        S_AXI_AWPROT;
   logic              S_AXI_AWREADY;
   logic [31:0]       S_AXI_WDATA;
   logic [3:0]        S_AXI_WSTRB;
   logic              S_AXI_WVALID;
   logic              S_AXI_WREADY;
   logic [1:0]        S_AXI_BRESP;
   logic              S_AXI_BVALID;
   logic              S_AXI_BREADY;
   logic [31:0]       S_AXI_ARADDR;
   logic              S_AXI_ARVALID;
   logic [2:0]        S_AXI_ARPROT;
   logic              S_AXI_ARREADY;
   logic [31:0]       S_AXI_RDATA;
   logic [1:0]        S_AXI_RRESP;
   logic              S_AXI_RVALID;
   logic              S_AXI_RREADY;
   logic [RC*32-1:0]  REG_OUT;
   logic [RC-1:0]     WR_STROBE;

   axi4_lite_reg_slave #(
      .AXI_DATA_WIDTH(32),
      .AXI_ADDR_WIDTH(32),
      .BASE_ADDR(BASE),
      .REG_COUNT(RC)
   ) dut (
      .clk(clk), .resetn(resetn),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID),
      .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
      .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
      .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
      .S_AXI_BREADY(S_AXI_BREADY),
      .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
      .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARREADY(S_AXI_ARREADY),
      .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .REG_OUT(REG_OUT), .WR_STROBE(WR_STROBE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model state
   bit            m_alive;
   bit            m_bvalid;
   logic [1:0]    m_bresp;
   bit            m_rvalid;
   logic [1:0]    m_rresp;
   logic [31:0]   m_rdata;
   logic [RC-1:0] m_strobe;
   logic [31:0]   m_regs [RC];
   logic [31:0]   m_aw_q [$];
   w_t            m_w_q [$];
   bit            m_aw_acc, m_w_acc, m_ar_acc;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endfunction

   function automatic bit e_awready();
      return m_alive && (m_aw_q.size() == 0) && !m_bvalid;
   endfunction

   function automatic bit e_wready();
      return m_alive && (m_w_q.size() == 0) && !m_bvalid;
   endfunction

   function automatic bit e_arready();
      return m_alive && !m_rvalid;
   endfunction

   // Byte offset from BASE in plain integer arithmetic.
   function automatic bit dec(input logic [31:0] a, output int idx);
      longint off;
      off = longint'(a) - longint'(BASE);
      idx = int'(off / 4);
      return (off >= 0) && (off < 4 * RC);
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      bit          aw_rdy, w_rdy, ar_rdy, ok;
      int          idx;
      logic [31:0] a;
      w_t          wd;
      m_aw_acc = 1'b0;
      m_w_acc  = 1'b0;
      m_ar_acc = 1'b0;
      if (!resetn) begin
         m_alive  = 1'b0;
         m_bvalid = 1'b0;
         m_bresp  = 2'b00;
         m_rvalid = 1'b0;
         m_rresp  = 2'b00;
         m_rdata  = 32'h0;
         m_strobe = '0;
         m_aw_q.delete();
         m_w_q.delete();
         for (int i = 0; i < RC; i++) m_regs[i] = 32'h0;
      end else begin
         aw_rdy   = e_awready();
         w_rdy    = e_wready();
         ar_rdy   = e_arready();
         m_aw_acc = S_AXI_AWVALID && aw_rdy;
         m_w_acc  = S_AXI_WVALID && w_rdy;
         m_ar_acc = S_AXI_ARVALID && ar_rdy;
         if (m_rvalid && S_AXI_RREADY) m_rvalid = 1'b0;
         if (m_ar_acc) begin
            ok       = dec(S_AXI_ARADDR, idx);
            m_rvalid = 1'b1;
            m_rdata  = ok ? m_regs[idx] : 32'h0;
            m_rresp  = ok ? 2'b00 : 2'b10;
         end
         if (m_bvalid && S_AXI_BREADY) m_bvalid = 1'b0;
         if (m_aw_acc) m_aw_q.push_back(S_AXI_AWADDR);
         if (m_w_acc) m_w_q.push_back({S_AXI_WDATA, S_AXI_WSTRB});
         m_strobe = '0;
         if (m_aw_q.size() > 0 && m_w_q.size() > 0) begin
            a        = m_aw_q.pop_front();
            wd       = m_w_q.pop_front();
            ok       = dec(a, idx);
            m_bvalid = 1'b1;
            if (ok) begin
               for (int b = 0; b < 4; b++)
                  if (wd.s[b]) m_regs[idx][8*b +: 8] = wd.d[8*b +: 8];
               m_strobe[idx] = 1'b1;
               m_bresp       = 2'b00;
            end else begin
               m_bresp = 2'b10;
            end
         end
         m_alive = 1'b1;
      end
   endtask

   // Per-cycle comparison of all DUT outputs against the model.
   always @(negedge clk) begin
      chk("awready", S_AXI_AWREADY, e_awready());
      chk("wready", S_AXI_WREADY, e_wready());
      chk("arready", S_AXI_ARREADY, e_arready());
      chk("bvalid", S_AXI_BVALID, m_bvalid);
      chk("rvalid", S_AXI_RVALID, m_rvalid);
      chk("wr_strobe", WR_STROBE, m_strobe);
      if (m_bvalid || !m_alive) chk("bresp", S_AXI_BRESP, m_bresp);
      if (m_rvalid || !m_alive) begin
         chk("rdata", S_AXI_RDATA, m_rdata);
         chk("rresp", S_AXI_RRESP, m_rresp);
      end
      for (int i = 0; i < RC; i++)
         chk($sformatf("reg_out%0d", i), REG_OUT[32*i +: 32], m_regs[i]);
   end

   task automatic cyc();
      model_step();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      S_AXI_AWVALID = 1'b0;
      S_AXI_WVALID  = 1'b0;
      S_AXI_ARVALID = 1'b0;
   endtask

   task automatic set_w(input logic [31:0] d, input logic [3:0] s);
      S_AXI_WDATA  = d;
      S_AXI_WSTRB  = s;
      S_AXI_WVALID = 1'b1;
   endtask

   task automatic set_aw(input logic [31:0] a);
      S_AXI_AWADDR  = a;
      S_AXI_AWVALID = 1'b1;
   endtask

   function automatic logic [31:0] rand_addr();
      if ($urandom_range(0, 9) == 0) return BASE - 32'($urandom_range(1, 16));
      return BASE + 32'($urandom_range(0, 79));
   endfunction

   initial begin
      resetn        = 1'b0;
      S_AXI_AWADDR  = 32'h0;
      S_AXI_AWPROT  = 3'b000;
      S_AXI_WDATA   = 32'h0;
      S_AXI_WSTRB   = 4'h0;
      S_AXI_ARADDR  = 32'h0;
      S_AXI_ARPROT  = 3'b000;
      S_AXI_BREADY  = 1'b1;
      S_AXI_RREADY  = 1'b1;
      idle();

      // Reset and first cycle after release
      repeat (3) cyc();
      chk("rst_awready", S_AXI_AWREADY, 1'b0);
      chk("rst_arready", S_AXI_ARREADY, 1'b0);
      resetn = 1'b1;
      cyc();
      chk("rel_awready", S_AXI_AWREADY, 1'b1);
      chk("rel_wready", S_AXI_WREADY, 1'b1);
      chk("rel_arready", S_AXI_ARREADY, 1'b1);

      // AW and W in the same cycle
      set_aw(BASE + 32'd8);
      set_w(32'hDEADBEEF, 4'hF);
      cyc();
      chk("same_bvalid", S_AXI_BVALID, 1'b1);
      chk("same_bresp", S_AXI_BRESP, 2'b00);
      chk("same_strobe", WR_STROBE, 12'h004);
      chk("same_reg2", REG_OUT[95:64], 32'hDEADBEEF);
      idle();
      cyc();
      chk("same_bclear", S_AXI_BVALID, 1'b0);
      chk("same_strobe_once", WR_STROBE, 12'h000);

      // W three cycles ahead of AW, partial strobe
      set_aw(BASE);
      set_w(32'hFFFFFFFF, 4'hF);
      cyc();
      idle();
      cyc();
      set_w(32'h11223344, 4'b0101);
      cyc();
      idle();
      for (int i = 0; i < 3; i++) begin
         chk("wfirst_awready", S_AXI_AWREADY, 1'b1);
         chk("wfirst_wready", S_AXI_WREADY, 1'b0);
         if (i < 2) cyc();
      end
      set_aw(BASE);
      cyc();
      chk("wfirst_bvalid", S_AXI_BVALID, 1'b1);
      chk("wfirst_reg0", REG_OUT[31:0], 32'hFF22FF44);
      idle();
      cyc();

      // Backpressure on B
      S_AXI_BREADY = 1'b0;
      set_aw(BASE + 32'd12);
      set_w(32'h12345678, 4'hF);
      cyc();
      S_AXI_WVALID = 1'b0;
      set_aw(BASE + 32'd16);
      for (int i = 0; i < 5; i++) begin
         chk("bp_bvalid", S_AXI_BVALID, 1'b1);
         chk("bp_bresp", S_AXI_BRESP, 2'b00);
         chk("bp_awready", S_AXI_AWREADY, 1'b0);
         chk("bp_wready", S_AXI_WREADY, 1'b0);
         cyc();
      end
      S_AXI_BREADY = 1'b1;
      cyc();
      chk("bp_bclear", S_AXI_BVALID, 1'b0);
      chk("bp_awready_after", S_AXI_AWREADY, 1'b1);
      set_w(32'hCAFEF00D, 4'hF);
      cyc();
      chk("bp_reg4", REG_OUT[159:128], 32'hCAFEF00D);
      idle();
      cyc();

      // Out-of-range read and write
      S_AXI_RREADY  = 1'b0;
      S_AXI_ARADDR  = BASE + 32'(4 * RC);
      S_AXI_ARVALID = 1'b1;
      cyc();
      chk("oor_rvalid", S_AXI_RVALID, 1'b1);
      chk("oor_rresp", S_AXI_RRESP, 2'b10);
      chk("oor_rdata", S_AXI_RDATA, 32'h0);
      S_AXI_ARVALID = 1'b0;
      S_AXI_RREADY  = 1'b1;
      set_aw(BASE + 32'(4 * RC));
      set_w(32'h55AA55AA, 4'hF);
      cyc();
      chk("oor_bresp", S_AXI_BRESP, 2'b10);
      chk("oor_strobe", WR_STROBE, 12'h000);
      chk("oor_reg0", REG_OUT[31:0], 32'hFF22FF44);
      idle();
      cyc();

      // Read and write of register 1 on the same edge
      S_AXI_RREADY  = 1'b0;
      set_aw(BASE + 32'd4);
      set_w(32'hA5A5A5A5, 4'hF);
      S_AXI_ARADDR  = BASE + 32'd4;
      S_AXI_ARVALID = 1'b1;
      cyc();
      idle();
      for (int i = 0; i < 3; i++) begin
         chk("rw_rvalid", S_AXI_RVALID, 1'b1);
         chk("rw_rdata_old", S_AXI_RDATA, 32'h0);
         cyc();
      end
      S_AXI_RREADY = 1'b1;
      cyc();
      S_AXI_ARVALID = 1'b1;
      cyc();
      chk("rw_rdata_new", S_AXI_RDATA, 32'hA5A5A5A5);
      S_AXI_ARVALID = 1'b0;
      cyc();

      // Reset between AW and W
      set_aw(BASE + 32'd20);
      cyc();
      idle();
      resetn = 1'b0;
      cyc();
      chk("mid_rst_bvalid", S_AXI_BVALID, 1'b0);
      chk("mid_rst_reg0", REG_OUT[31:0], 32'h0);
      chk("mid_rst_reg1", REG_OUT[63:32], 32'h0);
      resetn = 1'b1;
      cyc();
      set_w(32'h0BADC0DE, 4'hF);
      cyc();
      chk("mid_rst_no_commit", S_AXI_BVALID, 1'b0);
      idle();
      set_aw(BASE + 32'd20);
      cyc();
      chk("mid_rst_fresh_bvalid", S_AXI_BVALID, 1'b1);
      chk("mid_rst_fresh_reg5", REG_OUT[191:160], 32'h0BADC0DE);
      idle();
      cyc();

      // Randomized traffic with occasional resets
      for (int c = 0; c < 3000; c++) begin
         if (!resetn) resetn = 1'b1;
         else if ($urandom_range(0, 249) == 0) resetn = 1'b0;
         if (!S_AXI_AWVALID || m_aw_acc) begin
            S_AXI_AWVALID = ($urandom_range(0, 1) == 1);
            S_AXI_AWADDR  = rand_addr();
            S_AXI_AWPROT  = 3'($urandom_range(0, 7));
         end
         if (!S_AXI_WVALID || m_w_acc) begin
            S_AXI_WVALID = ($urandom_range(0, 1) == 1);
            S_AXI_WDATA  = $urandom();
            S_AXI_WSTRB  = 4'($urandom_range(0, 15));
         end
         if (!S_AXI_ARVALID || m_ar_acc) begin
            S_AXI_ARVALID = ($urandom_range(0, 1) == 1);
            S_AXI_ARADDR  = rand_addr();
            S_AXI_ARPROT  = 3'($urandom_range(0, 7));
         end
         S_AXI_BREADY = ($urandom_range(0, 9) < 6);
         S_AXI_RREADY = ($urandom_range(0, 9) < 6);
         cyc();
      end

      idle();
      resetn       = 1'b1;
      S_AXI_BREADY = 1'b1;
      S_AXI_RREADY = 1'b1;
      repeat (3) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/axi4_lite_reg_slave.md
AXI4_LITE_REG_SLAVE -- requirements
Module: axi4_lite_reg_slave

Interface
REQ-001 SHALL have parameter AXI_DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-002 SHALL have parameter AXI_ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of register 0, aligned to 64 bytes.
REQ-004 SHALL have parameter REG_COUNT, default 16, number of 32-bit registers; legal range 1..16.
REQ-005 SHALL use one clock and a synchronous, active-low reset: clk input 1, rising-edge clock for all logic.
REQ-006 resetn  input  1  synchronous active-low reset, sampled on clk.
REQ-007 S_AXI_AWADDR/AWVALID/AWPROT  in  AXI_ADDR_WIDTH/1/3; S_AXI_AWREADY  out  1: write address channel.
REQ-008 S_AXI_WDATA/WSTRB/WVALID  in  32/4/1; S_AXI_WREADY  out  1: write data channel.
REQ-009 S_AXI_BRESP  out  2; S_AXI_BVALID  out  1; S_AXI_BREADY  in  1: write response channel.
REQ-010 S_AXI_ARADDR/ARVALID/ARPROT  in  AXI_ADDR_WIDTH/1/3; S_AXI_ARREADY  out  1: read address channel.
REQ-011 S_AXI_RDATA  out  32; S_AXI_RRESP  out  2; S_AXI_RVALID  out  1; S_AXI_RREADY  in  1: read data channel.
REQ-012 REG_OUT  out  REG_COUNT*32  current contents; register n occupies bits [32n+31:32n].
REQ-013 WR_STROBE  out  REG_COUNT  one-cycle pulse on bit n when register n is written.

Function
REQ-014 Address decode SHALL use offset = ADDR - BASE_ADDR; index = offset[5:2]; offset[1:0] is ignored.
REQ-015 An address SHALL be in range iff 0 <= offset < 4*REG_COUNT (unsigned compare, no wrap).
REQ-016 AWPROT and ARPROT SHALL be ignored.
REQ-017 The write path SHALL capture AW and W independently, in either order or in the same cycle; each is held in its own latch.
REQ-018 AWREADY SHALL be 1 iff the AW latch is empty and BVALID is 0; WREADY SHALL be 1 iff the W latch is empty and BVALID is 0.
REQ-019 In the cycle after both latches are full, the slave SHALL commit the write, set BVALID=1, and clear both latches.
REQ-020 For an in-range commit, each byte lane i with WSTRB[i]=1 SHALL be updated, other lanes are unchanged, WR_STROBE[index] SHALL pulse, and BRESP SHALL be 2'b00 (OKAY).
REQ-021 For an out-of-range commit, no register SHALL change, no strobe SHALL pulse, and BRESP SHALL be 2'b10 (SLVERR).
REQ-022 A commit with WSTRB=0 SHALL leave the data unchanged but still pulse WR_STROBE and return OKAY.
REQ-023 BVALID and BRESP SHALL be held stable until BREADY=1; BVALID clears on the cycle after the BVALID&BREADY handshake, and no new AW/W is accepted while BVALID=1.
REQ-024 Minimum write throughput SHALL be one transaction per 3 cycles when BREADY is held at 1.
REQ-025 ARREADY SHALL be 1 iff RVALID is 0.
REQ-026 On an AR handshake in cycle N, RVALID SHALL be 1 in cycle N+1 with RDATA equal to the register value sampled in cycle N.
REQ-027 For an out-of-range read, RDATA SHALL be 0 and RRESP SHALL be 2'b10; in range, RRESP SHALL be 2'b00.
REQ-028 RDATA, RRESP and RVALID SHALL be held stable until RREADY=1; RVALID clears on the cycle after the handshake.
REQ-029 Read and write paths SHALL operate concurrently; a read sampled in the same cycle as a commit to the same register SHALL return the pre-write value.
REQ-030 REG_OUT SHALL reflect a committed write in the cycle after the commit.

Reset
REQ-031 While resetn=0: all registers 0, REG_OUT 0, WR_STROBE 0, both latches empty, BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0, AWREADY=0, WREADY=0, ARREADY=0.
REQ-032 In the first cycle after resetn rises, AWREADY, WREADY and ARREADY SHALL be 1.
REQ-033 A reset asserted mid-transaction SHALL abandon it: no commit, no response, and latched data discarded.

Verification
REQ-034 Test: AW=BASE+8 and W=32'hDEADBEEF with WSTRB=4'hF in the same cycle, BREADY=1 -> BVALID one cycle later, BRESP=00, WR_STROBE[2] pulses once, REG_OUT[95:64]=DEADBEEF.
REQ-035 Test: W (32'h11223344, WSTRB=4'b0101) three cycles before AW=BASE+0 over a register holding FFFFFFFF -> AWREADY stays 1 while W is held; register becomes FF22FF44.
REQ-036 Test: BREADY held 0 for 5 cycles -> BVALID and BRESP stable, AWREADY=WREADY=0 for all 5 cycles; a new AW is accepted only after the B handshake.
REQ-037 Test: AR=BASE+4*REG_COUNT, then AW/W to the same address -> RRESP=10 with RDATA=0; BRESP=10; no register changes and no strobe.
REQ-038 Test: AR to BASE+4 in the same cycle as a commit of 32'hA5A5A5A5 to register 1 (previously 0), RREADY=0 for 3 cycles -> RDATA=0 held stable, RVALID=1; a subsequent read returns A5A5A5A5.
REQ-039 Test: resetn pulsed low after the AW handshake but before W -> no BVALID; registers are 0; after release a fresh write completes normally.
